csa_pipe_skid: RTL

//  Parametrised, pipelined carry-skip adder/subtractor with valid/ready flow control.
//  It generalises the fixed 64-bit, 4-bit-block, single-register carry-skip adder:

---
 rtl/csa_pipe_skid.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/csa_pipe_skid.sv
// csa_pipe_skid: pipelined carry-skip adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit carry chain is cut into STAGES equal segments. Stage k adds
// segment k of the operands (a ripple of BLOCK-bit carry-skip blocks) and
// registers the partial sum, the carry into segment k+1 and the operands still
// to be processed. The last stage register drives the outputs directly.
//
// Every stage loads when it is empty or when its contents move on this cycle,
// so bubbles collapse and STAGES results can be buffered under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands present
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry in, add mode only
//   sub        0: a+b+cin, 1: a-b (a+~b+1, cin ignored)
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result (WIDTH bits)
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        two's-complement overflow
module csa_pipe_skid #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG  = WIDTH / STAGES;  // bits per pipeline segment
    localparam int unsigned BPS  = SEG / BLOCK;     // skip blocks per segment
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || BLOCK < 1 || (WIDTH % BLOCK) != 0 ||
        ((WIDTH / BLOCK) % STAGES) != 0) begin : g_bad_params
        $error("csa_pipe_skid: WIDTH must divide into BLOCKs, and blocks into STAGES");
    end

    // One segment: ripple of carry-skip blocks. A block whose propagate bits are
    // all set forwards its carry-in straight to its carry-out.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c_in);
        logic [SEG-1:0]   s;
        logic [BLOCK-1:0] p;
        logic             c_blk;
        logic             c_rip;
        s     = '0;
        p     = '0;
        c_blk = c_in;
        for (int blk = 0; blk < int'(BPS); blk++) begin
            c_rip = c_blk;
            for (int i = 0; i < int'(BLOCK); i++) begin
                p[i]                 = x[blk*BLOCK+i] ^ y[blk*BLOCK+i];
                s[blk*BLOCK+i]       = p[i] ^ c_rip;
                c_rip                = (x[blk*BLOCK+i] & y[blk*BLOCK+i]) | (c_rip & p[i]);
            end
            c_blk = (&p) ? c_blk : c_rip;
        end
        return {c_blk, s};
    endfunction

    // Stage state
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];  // holds b' (already inverted for subtract)
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic              ovf_q;

    // Per-stage sources and segment results
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] seg_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [SEG-1:0]    seg_s   [STAGES];

    // stage_ready[k]: stage k loads this cycle. stage_ready[STAGES] is the consumer.
    logic [STAGES:0]   stage_ready;
    logic [WIDTH-1:0]  in_bp;
    logic              in_c0;
    logic              ovf_d;

    assign in_bp = sub ? ~b : b;
    assign in_c0 = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src_in
            assign src_valid[k] = in_valid;
            assign src_a[k]     = a;
            assign src_b[k]     = in_bp;
            assign src_c[k]     = in_c0;
            assign src_sum[k]   = '0;
        end else begin : g_src_prev
            assign src_valid[k] = valid_q[k-1];
            assign src_a[k]     = a_q[k-1];
            assign src_b[k]     = b_q[k-1];
            assign src_c[k]     = carry_q[k-1];
            assign src_sum[k]   = sum_q[k-1];
        end

        assign {seg_c[k], seg_s[k]} = seg_add(src_a[k][k*SEG +: SEG],
                                              src_b[k][k*SEG +: SEG],
                                              src_c[k]);

        // Segments above k are still zero in src_sum, so OR-ing inserts segment k.
        assign sum_d[k] = src_sum[k] | (WIDTH'(seg_s[k]) << (k * SEG));
    end

    // Overflow is decided by the segment holding the MSB, i.e. the last stage.
    assign ovf_d = (src_a[LAST][MSB] == src_b[LAST][MSB]) &&
                   (seg_s[LAST][SEG-1] != src_a[LAST][MSB]);

    // Ready chain: a stage loads when empty or when the stage after it loads.
    always_comb begin
        stage_ready[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            stage_ready[k] = !valid_q[k] || stage_ready[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (stage_ready[k]) begin
                    valid_q[k] <= src_valid[k];
                    // Data only updates on a real load, keeping idle stages quiet.
                    if (src_valid[k]) begin
                        a_q[k]     <= src_a[k];
                        b_q[k]     <= src_b[k];
                        carry_q[k] <= seg_c[k];
                        sum_q[k]   <= sum_d[k];
                    end
                end
            end
            if (stage_ready[LAST] && src_valid[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule
